// File: rtl/pc_sequencer.sv
// pc_sequencer: registered fetch PC for the RISC-V IF stage.
// Picks jump target, branch target, held PC or sequential PC+INSTR_BYTES.
// After any redirect it opens a fixed squash window, and it traps
// misaligned targets to TRAP_VEC.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high
//   Stall        in   hold PC (sequential advance suppressed)
//   Branch       in   resolved taken branch
//   BranchTarget in   branch destination
//   Jump         in   unconditional jump (wins over Branch)
//   JumpTarget   in   jump destination
//   PC           out  current fetch address (registered)
//   PCPlus       out  PC + INSTR_BYTES, wrapping (combinational)
//   PCValid      out  fetch at PC is valid (~Flush)
//   Flush        out  squash this cycle's fetch (registered)
//   Misaligned   out  one-cycle pulse alongside PC=TRAP_VEC (registered)
module pc_sequencer #(
  parameter int unsigned         ADDR_W       = 12,
  parameter int unsigned         INSTR_BYTES  = 4,
  parameter logic [ADDR_W-1:0]   RESET_PC     = '0,
  parameter logic [ADDR_W-1:0]   TRAP_VEC     = ADDR_W'(12'hFF0),
  parameter int unsigned         FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Stall,
  input  logic              Branch,
  input  logic [ADDR_W-1:0] BranchTarget,
  input  logic              Jump,
  input  logic [ADDR_W-1:0] JumpTarget,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] PCPlus,
  output logic              PCValid,
  output logic              Flush,
  output logic              Misaligned
);

  localparam int unsigned CNT_W = 3;
  // Low address bits that must be zero; all-zero mask disables the check
  // when INSTR_BYTES is 1.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INSTR_BYTES - 1);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   fcnt;
  logic [ADDR_W-1:0]  tgt;
  logic               redirect;
  logic               tgt_misaligned;

  // Redirect target selection: Jump has priority over Branch.
  always_comb begin
    tgt            = Jump ? JumpTarget : BranchTarget;
    redirect       = Jump | Branch;
    tgt_misaligned = |(tgt & ALIGN_MASK);
  end

  assign PCPlus  = PC + ADDR_W'(INSTR_BYTES);
  assign PCValid = ~Flush;

  // Sequencer state, PC and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      PC         <= RESET_PC;
      fcnt       <= '0;
      Flush      <= 1'b0;
      Misaligned <= 1'b0;
    end else begin
      Misaligned <= 1'b0;
      case (state)
        RUN: begin
          if (redirect) begin
            if (tgt_misaligned) begin
              PC         <= TRAP_VEC;
              Misaligned <= 1'b1;
            end else begin
              PC <= tgt;
            end
            state <= FLUSH;
            fcnt  <= CNT_W'(FLUSH_CYCLES);
            Flush <= 1'b1;
          end else if (!Stall) begin
            PC <= PCPlus;
          end
        end
        FLUSH: begin
          // PC holds and redirects are dropped; Stall does not stretch the window.
          if (fcnt <= CNT_W'(1)) begin
            state <= RUN;
            fcnt  <= '0;
            Flush <= 1'b0;
          end else begin
            fcnt <= fcnt - CNT_W'(1);
          end
        end
        default: begin
          state <= RUN;
          fcnt  <= '0;
          Flush <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default parameters).
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall;
  logic        Branch;
  logic [11:0] BranchTarget;
  logic        Jump;
  logic [11:0] JumpTarget;
  logic [11:0] PC;
  logic [11:0] PCPlus;
  logic        PCValid;
  logic        Flush;
  logic        Misaligned;

  int total = 0;
  int bad   = 0;

  pc_sequencer #(
    .ADDR_W(12), .INSTR_BYTES(4), .RESET_PC(12'h000),
    .TRAP_VEC(12'hFF0), .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .Stall(Stall),
    .Branch(Branch), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpTarget(JumpTarget),
    .PC(PC), .PCPlus(PCPlus), .PCValid(PCValid),
    .Flush(Flush), .Misaligned(Misaligned)
  );

  always #5 clk = ~clk;

  // One clock edge; outputs are observed 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({PC, PCPlus, PCValid, Flush, Misaligned} !== {12'h000, 12'h004, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: PC=%h PCPlus=%h V=%b F=%b M=%b want 000 004 1 0 0",
               PC, PCPlus, PCValid, Flush, Misaligned);
    end
    for (int i = 1; i < 4; i++) begin
      tick();
      total++;
      if ({PC, PCValid, Flush} !== {12'(i * 4), 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL seq_advance[%0d]: PC=%h V=%b F=%b want %h 1 0",
                 i, PC, PCValid, Flush, 12'(i * 4));
      end
    end
  endtask

  task automatic test_branch();
    do_reset();
    tick();
    tick();
    total++;
    if (PC !== 12'h008) begin
      bad++;
      $display("FAIL branch_pre: PC=%h want 008", PC);
    end
    Branch = 1'b1; BranchTarget = 12'h1F0;
    tick();
    Branch = 1'b0; BranchTarget = 12'h000;
    total++;
    if ({PC, Flush, PCValid} !== {12'h1F0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL branch_flush1: PC=%h F=%b V=%b want 1f0 1 0", PC, Flush, PCValid);
    end
    tick();
    total++;
    if ({PC, Flush, PCValid} !== {12'h1F0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL branch_flush2: PC=%h F=%b V=%b want 1f0 1 0", PC, Flush, PCValid);
    end
    tick();
    total++;
    if ({PC, Flush, PCValid} !== {12'h1F0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL branch_valid: PC=%h F=%b V=%b want 1f0 0 1", PC, Flush, PCValid);
    end
    tick();
    total++;
    if ({PC, Flush} !== {12'h1F4, 1'b0}) begin
      bad++;
      $display("FAIL branch_next: PC=%h F=%b want 1f4 0", PC, Flush);
    end
  endtask

  task automatic test_jump_over_branch();
    logic [11:0] exp_pc [4] = '{12'h040, 12'h040, 12'h040, 12'h044};
    logic        exp_fl [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    Jump = 1'b1;   JumpTarget   = 12'h040;
    Branch = 1'b1; BranchTarget = 12'h100;
    tick();
    Jump = 1'b0; Branch = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      total++;
      if ({PC, Flush} !== {exp_pc[i], exp_fl[i]}) begin
        bad++;
        $display("FAIL jump_wins[%0d]: PC=%h F=%b want %h %b", i, PC, Flush, exp_pc[i], exp_fl[i]);
      end
    end
  endtask

  task automatic test_misaligned();
    logic [11:0] exp_pc [8] = '{12'hFF0, 12'hFF0, 12'hFF0, 12'hFF4,
                                12'hFF8, 12'hFFC, 12'h000, 12'h004};
    logic        exp_fl [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        exp_mi [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    Jump = 1'b1; JumpTarget = 12'h022;
    tick();
    Jump = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      total++;
      if ({PC, Flush, Misaligned} !== {exp_pc[i], exp_fl[i], exp_mi[i]}) begin
        bad++;
        $display("FAIL misaligned[%0d]: PC=%h F=%b M=%b want %h %b %b",
                 i, PC, Flush, Misaligned, exp_pc[i], exp_fl[i], exp_mi[i]);
      end
      if (i == 5) begin
        total++;
        if (PCPlus !== 12'h000) begin
          bad++;
          $display("FAIL pcplus_wrap: PCPlus=%h want 000", PCPlus);
        end
      end
    end
  endtask

  task automatic test_stall_redirect();
    do_reset();
    repeat (4) tick();
    Stall = 1'b1;
    tick();
    tick();
    total++;
    if (PC !== 12'h010) begin
      bad++;
      $display("FAIL stall_hold: PC=%h want 010", PC);
    end
    Branch = 1'b1; BranchTarget = 12'h080;
    tick();
    total++;
    if ({PC, Flush} !== {12'h080, 1'b1}) begin
      bad++;
      $display("FAIL stall_redirect: PC=%h F=%b want 080 1", PC, Flush);
    end
    BranchTarget = 12'h200;
    tick();
    Branch = 1'b0;
    total++;
    if ({PC, Flush} !== {12'h080, 1'b1}) begin
      bad++;
      $display("FAIL flush_ignores_branch: PC=%h F=%b want 080 1", PC, Flush);
    end
    tick();
    total++;
    if ({PC, Flush, PCValid} !== {12'h080, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL stall_window_end: PC=%h F=%b V=%b want 080 0 1", PC, Flush, PCValid);
    end
    tick();
    total++;
    if ({PC, Flush} !== {12'h080, 1'b0}) begin
      bad++;
      $display("FAIL stall_after_flush: PC=%h F=%b want 080 0", PC, Flush);
    end
    Stall = 1'b0;
    tick();
    total++;
    if (PC !== 12'h084) begin
      bad++;
      $display("FAIL stall_release: PC=%h want 084", PC);
    end
  endtask

  task automatic test_reset_mid_flush();
    Jump = 1'b1; JumpTarget = 12'h302;
    tick();
    Jump = 1'b0;
    total++;
    if ({PC, Flush, Misaligned} !== {12'hFF0, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL rmf_pre: PC=%h F=%b M=%b want ff0 1 1", PC, Flush, Misaligned);
    end
    do_reset();
    total++;
    if ({PC, Flush, PCValid, Misaligned} !== {12'h000, 1'b0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL rmf_reset: PC=%h F=%b V=%b M=%b want 000 0 1 0",
               PC, Flush, PCValid, Misaligned);
    end
    tick();
    total++;
    if ({PC, Flush} !== {12'h004, 1'b0}) begin
      bad++;
      $display("FAIL rmf_run: PC=%h F=%b want 004 0", PC, Flush);
    end
  endtask

  initial begin
    reset = 1'b0; Stall = 1'b0;
    Branch = 1'b0; BranchTarget = 12'h000;
    Jump = 1'b0; JumpTarget = 12'h000;
    test_reset();
    test_branch();
    test_jump_over_branch();
    test_misaligned();
    test_stall_redirect();
    test_reset_mid_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
